// File: rtl/led_burst_ctrl.sv
// LED burst sequencer: on start, blinks the LED num_blinks times with
// millisecond-programmable on/off phases, then pulses done for one cycle.
module led_burst_ctrl #(
   parameter int unsigned TICK_DIV = 100000,
   parameter int unsigned MS_W     = 10,
   parameter int unsigned N_W      = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            abort,
   input  logic [N_W-1:0]  num_blinks,
   input  logic [MS_W-1:0] on_ms,
   input  logic [MS_W-1:0] off_ms,
   output logic            busy,
   output logic            done,
   output logic            LED
);

   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ON,
      S_OFF,
      S_DONE
   } state_e;

   state_e          state_q, state_d;
   logic [PW-1:0]   presc_q, presc_d;
   logic [MS_W-1:0] ms_q, ms_d;
   logic [MS_W-1:0] on_q, on_d;
   logic [MS_W-1:0] off_q, off_d;
   logic [N_W-1:0]  rem_q, rem_d;
   logic            led_q, led_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;

   logic            tick_c;
   logic [MS_W-1:0] on_last_c;
   logic [MS_W-1:0] off_last_c;

   assign tick_c     = (state_q != S_IDLE) && (presc_q == PW'(TICK_DIV - 1));
   // A zero duration behaves as one millisecond.
   assign on_last_c  = (on_q  == '0) ? '0 : on_q  - MS_W'(1);
   assign off_last_c = (off_q == '0) ? '0 : off_q - MS_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         presc_q <= '0;
         ms_q    <= '0;
         on_q    <= '0;
         off_q   <= '0;
         rem_q   <= '0;
         led_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         ms_q    <= ms_d;
         on_q    <= on_d;
         off_q   <= off_d;
         rem_q   <= rem_d;
         led_q   <= led_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      ms_d    = ms_q;
      on_d    = on_q;
      off_d   = off_q;
      rem_d   = rem_q;

      // Prescaler idles at zero so every burst starts from a clean tick phase.
      if (state_q == S_IDLE) begin
         presc_d = '0;
      end else begin
         presc_d = tick_c ? '0 : presc_q + PW'(1);
      end

      case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               if (num_blinks != '0) begin
                  rem_d   = num_blinks;
                  on_d    = on_ms;
                  off_d   = off_ms;
                  ms_d    = '0;
                  state_d = S_ON;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_ON: begin
            if (tick_c) begin
               if (ms_q == on_last_c) begin
                  ms_d    = '0;
                  state_d = S_OFF;
               end else begin
                  ms_d = ms_q + MS_W'(1);
               end
            end
         end
         S_OFF: begin
            if (tick_c) begin
               if (ms_q == off_last_c) begin
                  ms_d    = '0;
                  rem_d   = rem_q - N_W'(1);
                  state_d = (rem_q == N_W'(1)) ? S_DONE : S_ON;
               end else begin
                  ms_d = ms_q + MS_W'(1);
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (abort && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
      end

      led_d  = (state_d == S_ON);
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   assign LED  = led_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_led_burst_ctrl.sv
// Randomized bench for led_burst_ctrl: a timeline model predicts every output
// change per burst; a monitor pops and compares each observed change.
module tb_led_burst_ctrl;

   localparam int TD   = 4;
   localparam int MS_W = 10;
   localparam int N_W  = 4;

   typedef struct {
      int         t;
      logic [2:0] v;   // {LED, busy, done}
   } ev_t;

   logic            clk;
   logic            rst_n;
   logic            start;
   logic            abort;
   logic [N_W-1:0]  num_blinks;
   logic [MS_W-1:0] on_ms;
   logic [MS_W-1:0] off_ms;
   logic            busy;
   logic            done;
   logic            LED;

   int         cyc;
   int         checks;
   int         errors;
   bit         mon_en;
   logic [2:0] prev_v;
   ev_t        exp_q[$];

   led_burst_ctrl #(
      .TICK_DIV(TD),
      .MS_W    (MS_W),
      .N_W     (N_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .abort     (abort),
      .num_blinks(num_blinks),
      .on_ms     (on_ms),
      .off_ms    (off_ms),
      .busy      (busy),
      .done      (done),
      .LED       (LED)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every change of the output triple must match the next predicted event.
   always @(negedge clk) begin
      logic [2:0] cur;
      ev_t        e;
      cur = {LED, busy, done};
      if (mon_en && (cur != prev_v)) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_change: got %b at cyc %0d, nothing expected", cur, cyc);
         end else begin
            e = exp_q.pop_front();
            if (e.t != cyc || e.v != cur) begin
               errors++;
               $display("FAIL event: got %b at cyc %0d expected %b at cyc %0d",
                        cur, cyc, e.v, e.t);
            end
         end
      end
      prev_v = cur;
   end

   // Predicts the burst timeline from start; ab: -1 none, -2 random, else offset from burst start.
   task automatic run_burst(input int n, input int on, input int off, input int ab, input bit sb);
      ev_t ev[$];
      int  s, t, oe, fe, tend, a, b;
      num_blinks = N_W'(n);
      on_ms      = MS_W'(on);
      off_ms     = MS_W'(off);
      start      = 1'b1;
      s  = cyc + 1;
      oe = (on  == 0) ? 1 : on;
      fe = (off == 0) ? 1 : off;
      if (n == 0) begin
         ev.push_back('{s, 3'b011});
         tend = s + 1;
      end else begin
         t = s;
         ev.push_back('{t, 3'b110});
         for (int i = 0; i < n; i++) begin
            t += oe * TD;
            ev.push_back('{t, 3'b010});
            t += fe * TD;
            ev.push_back('{t, (i < n - 1) ? 3'b110 : 3'b011});
         end
         tend = t + 1;
      end
      ev.push_back('{tend, 3'b000});
      a = -1;
      if (ab == -2) a = int'($urandom_range(32'(tend - 1), 32'(s)));
      else if (ab >= 0) a = s + ab;
      if (a >= 0) begin
         foreach (ev[i]) if (ev[i].t <= a) exp_q.push_back(ev[i]);
         exp_q.push_back('{a + 1, 3'b000});
         tend = a + 1;
      end else begin
         foreach (ev[i]) exp_q.push_back(ev[i]);
      end
      @(negedge clk);
      start      = 1'b0;
      num_blinks = N_W'($urandom);
      on_ms      = MS_W'($urandom);
      off_ms     = MS_W'($urandom);
      if (a >= 0) begin
         while (cyc < a) @(negedge clk);
         abort = 1'b1;
         @(negedge clk);
         abort = 1'b0;
      end
      if (sb) begin
         b = int'($urandom_range(32'(tend - 1), 32'(s)));
         while (cyc < b) @(negedge clk);
         num_blinks = N_W'($urandom_range(4, 1));
         on_ms      = MS_W'($urandom_range(3));
         start      = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      while (cyc < tend) @(negedge clk);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      checks     = 0;
      errors     = 0;
      mon_en     = 1'b0;
      prev_v     = 3'b000;
      rst_n      = 1'b0;
      start      = 1'b0;
      abort      = 1'b0;
      num_blinks = '0;
      on_ms      = '0;
      off_ms     = '0;

      #12;
      chk("reset_led", int'(LED), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Asynchronous reset in the middle of an ON phase.
      num_blinks = 4'd2; on_ms = 10'd3; off_ms = 10'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_led", int'(LED), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_done", int'(done), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      mon_en = 1'b1;

      run_burst(3, 2, 1, -1, 1'b0);   // basic burst
      repeat (2) @(negedge clk);
      run_burst(0, 2, 2, -1, 1'b0);   // zero blinks
      repeat (2) @(negedge clk);
      run_burst(2, 0, 0, -1, 1'b0);   // zero durations
      run_burst(2, 1, 2, -1, 1'b1);   // start in first idle cycle, plus start while busy
      run_burst(1, 1, 2, 6, 1'b0);    // abort during OFF
      @(negedge clk);

      // abort and start together in IDLE: nothing happens
      num_blinks = 4'd2; on_ms = 10'd1; off_ms = 10'd1;
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      repeat (3) @(negedge clk);
      chk("idle_abort_busy", int'(busy), 0);

      for (int k = 0; k < 24; k++) begin
         int mode;
         mode = int'($urandom_range(3));
         run_burst(int'($urandom_range(4)), int'($urandom_range(3)), int'($urandom_range(3)),
                   (mode == 1) ? -2 : -1, mode == 2);
         repeat (int'($urandom_range(2))) @(negedge clk);
      end

      repeat (5) @(negedge clk);
      #1;
      chk("queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/led_burst_ctrl.md
# led_burst_ctrl

Sequencer for an on-board LED. On a `start` request it drives the LED through a programmable burst of N on/off blinks, with on and off durations counted in milliseconds. It replaces the free-running-counter blink scheme where the blink count, duty and period must be controlled at run time. It sits between user logic (push-button debouncer, status FSMs) and the LED output pin.

## Interface
- `TICK_DIV`, default 100000: clk cycles per millisecond tick (100 MHz on-board oscillator); must be ≥ 2.
- `MS_W`, default 10: width of the on/off duration fields, in ms.
- `N_W`, default 4: width of the blink-count field.

- `clk`  in  1  system clock, 100 MHz on-board oscillator.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a burst; sampled only in IDLE.
- `abort`  in  1  synchronous abort of a running burst.
- `num_blinks`  in  N_W  number of on/off pairs in the burst.
- `on_ms`  in  MS_W  on-phase duration in ms; 0 is treated as 1.
- `off_ms`  in  MS_W  off-phase duration in ms; 0 is treated as 1.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `done`  out  1  one-cycle pulse at burst completion.
- `LED`  out  1  registered LED drive, 1 = lit.

## Operation
- FSM states: IDLE, ON, OFF, DONE.
- Reset (`rst_n`=0, asynchronous):
  - State goes to IDLE.
  - `LED`=0, `busy`=0, `done`=0.
  - Prescaler, ms counter and remaining-count register clear to 0.
- IDLE behaviour:
  - Prescaler is held at 0.
  - `start`=1 with `num_blinks`≠0: latch `num_blinks`, `on_ms`, `off_ms` into internal registers, then go to ON with ms counter=0. Inputs may change afterwards without effect.
  - `start`=1 with `num_blinks`=0: go to DONE directly. `LED` stays 0.
- Prescaler: counts 0..TICK_DIV-1 while not in IDLE. `tick`=1 in the cycle where count==TICK_DIV-1, then wraps to 0.
- ON state:
  - `LED`=1.
  - On each `tick`, ms counter increments.
  - When `tick` occurs with ms counter==max(on_ms,1)-1: clear ms counter and go to OFF.
- OFF state:
  - `LED`=0.
  - Same counting rule using max(off_ms,1).
  - At end of phase, decrement the remaining count. If the remaining count was 1, go to DONE; otherwise go to ON.
- DONE state: `done`=1 for exactly one cycle, then IDLE.
- `busy` = (state≠IDLE), so `busy` is also high during DONE.
- `abort`=1 in ON, OFF or DONE: next state is IDLE, `LED`=0, no `done` pulse.
- `abort` and `start` both high in IDLE: abort wins and the FSM stays IDLE.
- `start` while busy is ignored. It is neither queued nor restarting.
- All outputs are registered; no combinational path from inputs to outputs.

## Timing
- `start` sampled at edge k → state=ON, `LED`=1, `busy`=1 from edge k+1.
- ON phase length: exactly max(on_ms,1)×TICK_DIV cycles.
- OFF phase length: exactly max(off_ms,1)×TICK_DIV cycles.
- Full burst: N×(ON+OFF) cycles, followed by one DONE cycle. The next `start` is accepted in the cycle after DONE, i.e. the first IDLE cycle.
- `num_blinks`=0: `busy`=1 and `done`=1 for the single cycle k+1; IDLE at k+2.
- `abort` sampled at edge j → `LED`=0, `busy`=0 from edge j+1.
- The prescaler restarts from 0 for every accepted burst, so phase boundaries never depend on history.

## Test plan
- Reset mid-burst: assert `rst_n`=0 during ON → `LED`, `busy`, `done` go to 0 immediately, without waiting for a clk edge. After release the FSM is IDLE and a fresh `start` behaves normally.
- Basic burst (`TICK_DIV`=4, `num_blinks`=3, `on_ms`=2, `off_ms`=1):
  - `LED` shows exactly 3 high pulses of 8 cycles, separated by low gaps of 4 cycles.
  - `busy` is high for 36+1 cycles.
  - `done` pulses once in the cycle after the last OFF.
- Zero cases:
  - `num_blinks`=0 → `done` pulse at k+1 and `LED` never rises.
  - `on_ms`=0, `off_ms`=0 → 4-cycle on and 4-cycle off phases (each duration treated as 1).
- Start while busy:
  - Pulse `start` with new parameters mid-burst → burst timing unchanged, a single `done` pulse.
  - `start` in the first IDLE cycle after `done` → new burst begins at the next edge.
- Abort:
  - `abort` during OFF → `LED`=0, `busy`=0 next cycle, no `done` pulse.
  - `abort`+`start` together in IDLE → FSM stays IDLE.
